// File: rtl/qubit_lut_bank_ctrl.sv
// Double-buffered qubit coordinate table: the host fills a shadow bank, and a commit copies it
// into the active bank that the coordinate matcher sees, only during frame blanking.
module qubit_lut_bank_ctrl #(
   parameter int NUM_QUBITS     = 16,
   parameter int COORD_WIDTH    = 12,
   parameter int QUBIT_ID_WIDTH = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_wr_valid,
   output logic                              o_wr_ready,
   input  logic [QUBIT_ID_WIDTH-1:0]         i_wr_index,
   input  logic [COORD_WIDTH-1:0]            i_wr_x,
   input  logic [COORD_WIDTH-1:0]            i_wr_y,
   input  logic                              i_commit,
   input  logic                              i_sync_fval,
   output logic [NUM_QUBITS*COORD_WIDTH-1:0] o_q_x,
   output logic [NUM_QUBITS*COORD_WIDTH-1:0] o_q_y,
   output logic                              o_lut_valid,
   output logic                              o_pending,
   output logic                              o_swap_done,
   output logic                              o_index_err,
   output logic [CNT_WIDTH-1:0]              o_swap_count
);

   localparam int TW = NUM_QUBITS * COORD_WIDTH;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_PENDING = 2'd1,
      S_SWAP    = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_wr_ready;
   logic                  w_wr_fire;
   logic                  w_idx_ok;
   logic [TW-1:0]         r_sh_x;
   logic [TW-1:0]         r_sh_y;
   logic [TW-1:0]         r_act_x;
   logic [TW-1:0]         r_act_y;
   logic                  r_lut_valid;
   logic                  r_pending;
   logic                  r_swap_done;
   logic                  r_index_err;
   logic [CNT_WIDTH-1:0]  r_swap_count;

   assign w_wr_fire = i_wr_valid & w_wr_ready;
   assign w_idx_ok  = (int'(i_wr_index) < NUM_QUBITS);

   always_comb begin
      w_next     = r_state;
      w_wr_ready = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_wr_ready = 1'b1;
            if (i_commit) w_next = S_PENDING;
         end
         S_PENDING: begin
            // Hold off the copy until the frame goes inactive, however long that takes.
            if (!i_sync_fval) w_next = S_SWAP;
         end
         S_SWAP: begin
            w_next = S_LOAD;
         end
         default: begin
            w_next = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   // Shadow bank: a write accepted in the commit cycle still lands before the copy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh_x <= '0;
         r_sh_y <= '0;
      end else begin
         for (int i = 0; i < NUM_QUBITS; i++) begin
            if (w_wr_fire && w_idx_ok && (i_wr_index == QUBIT_ID_WIDTH'(i))) begin
               r_sh_x[i*COORD_WIDTH +: COORD_WIDTH] <= i_wr_x;
               r_sh_y[i*COORD_WIDTH +: COORD_WIDTH] <= i_wr_y;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_act_x      <= '0;
         r_act_y      <= '0;
         r_lut_valid  <= 1'b0;
         r_pending    <= 1'b0;
         r_swap_done  <= 1'b0;
         r_index_err  <= 1'b0;
         r_swap_count <= '0;
      end else begin
         r_pending   <= (w_next != S_LOAD);
         r_swap_done <= (r_state == S_SWAP);
         r_index_err <= w_wr_fire & ~w_idx_ok;
         if (r_state == S_SWAP) begin
            r_act_x      <= r_sh_x;
            r_act_y      <= r_sh_y;
            r_lut_valid  <= 1'b1;
            r_swap_count <= r_swap_count + 1'b1;
         end
      end
   end

   assign o_wr_ready   = w_wr_ready;
   assign o_q_x        = r_act_x;
   assign o_q_y        = r_act_y;
   assign o_lut_valid  = r_lut_valid;
   assign o_pending    = r_pending;
   assign o_swap_done  = r_swap_done;
   assign o_index_err  = r_index_err;
   assign o_swap_count = r_swap_count;

endmodule

// File: tb/tb_qubit_lut_bank_ctrl.sv
// Directed bench for qubit_lut_bank_ctrl: table-driven writes plus hand-written commit,
// frame-hold, reset and counter-wrap sequences.
module tb_qubit_lut_bank_ctrl;

   localparam int N  = 16;
   localparam int CW = 12;
   localparam int IW = 5;
   localparam int TW = N * CW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_valid;
   logic [IW-1:0]  wr_index;
   logic [CW-1:0]  wr_x;
   logic [CW-1:0]  wr_y;
   logic           commit;
   logic           fval;

   logic           wr_ready, lut_valid, pending, swap_done, index_err;
   logic [TW-1:0]  q_x, q_y;
   logic [15:0]    swap_count;

   logic           n_ready, n_lut_valid, n_pending, n_swap_done, n_index_err;
   logic [TW-1:0]  n_q_x, n_q_y;
   logic [1:0]     n_swap_count;

   always #5 clk = ~clk;

   qubit_lut_bank_ctrl #(.NUM_QUBITS(N), .COORD_WIDTH(CW), .QUBIT_ID_WIDTH(IW), .CNT_WIDTH(16)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
      .i_wr_index(wr_index), .i_wr_x(wr_x), .i_wr_y(wr_y), .i_commit(commit),
      .i_sync_fval(fval), .o_q_x(q_x), .o_q_y(q_y), .o_lut_valid(lut_valid),
      .o_pending(pending), .o_swap_done(swap_done), .o_index_err(index_err),
      .o_swap_count(swap_count)
   );

   // Narrow-counter copy on the same stimulus, so counter wrap is reached in a few swaps.
   qubit_lut_bank_ctrl #(.NUM_QUBITS(N), .COORD_WIDTH(CW), .QUBIT_ID_WIDTH(IW), .CNT_WIDTH(2)) u_dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(n_ready),
      .i_wr_index(wr_index), .i_wr_x(wr_x), .i_wr_y(wr_y), .i_commit(commit),
      .i_sync_fval(fval), .o_q_x(n_q_x), .o_q_y(n_q_y), .o_lut_valid(n_lut_valid),
      .o_pending(n_pending), .o_swap_done(n_swap_done), .o_index_err(n_index_err),
      .o_swap_count(n_swap_count)
   );

   typedef struct {
      logic [IW-1:0] idx;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          err;
   } wvec_t;

   wvec_t          tbl[6];
   int             n_checks = 0;
   int             n_pass   = 0;
   int             exp_cnt  = 0;
   logic [TW-1:0]  m_sx, m_sy, m_ax, m_ay;
   logic [TW-1:0]  prev_x, prev_y;

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_sx = '0; m_sy = '0; m_ax = '0; m_ay = '0;
      exp_cnt = 0;
   endtask

   task automatic do_write(input logic [IW-1:0] idx, input logic [CW-1:0] x,
                           input logic [CW-1:0] y, input logic err);
      wr_valid = 1'b1; wr_index = idx; wr_x = x; wr_y = y;
      tick();
      wr_valid = 1'b0;
      chk("index_err", TW'(index_err), TW'(err));
      if (int'(idx) < N) begin
         m_sx[int'(idx)*CW +: CW] = x;
         m_sy[int'(idx)*CW +: CW] = y;
      end
   endtask

   task automatic swap_checks(input string tag);
      m_ax = m_sx; m_ay = m_sy;
      exp_cnt++;
      chk({tag, "_q_x"}, q_x, m_ax);
      chk({tag, "_q_y"}, q_y, m_ay);
      chk({tag, "_swap_done"}, TW'(swap_done), TW'(1));
      chk({tag, "_pending"}, TW'(pending), TW'(0));
      chk({tag, "_lut_valid"}, TW'(lut_valid), TW'(1));
      chk({tag, "_count"}, TW'(swap_count), TW'(exp_cnt % 65536));
      chk({tag, "_narrow_count"}, TW'(n_swap_count), TW'(exp_cnt % 4));
      chk({tag, "_narrow_done"}, TW'(n_swap_done), TW'(1));
      chk({tag, "_narrow_q_x"}, n_q_x, m_ax);
   endtask

   task automatic commit_fval0(input string tag);
      fval = 1'b0; commit = 1'b1;
      tick();
      commit = 1'b0;
      chk({tag, "_e0_pending"}, TW'(pending), TW'(1));
      chk({tag, "_e0_ready"}, TW'(wr_ready), TW'(0));
      chk({tag, "_e0_done"}, TW'(swap_done), TW'(0));
      tick();
      chk({tag, "_e1_done"}, TW'(swap_done), TW'(0));
      chk({tag, "_e1_q_x"}, q_x, m_ax);
      tick();
      swap_checks(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{idx: 5'd0,  x: 12'd100,  y: 12'd50,   err: 1'b0};
      tbl[1] = '{idx: 5'd3,  x: 12'd200,  y: 12'd75,   err: 1'b0};
      tbl[2] = '{idx: 5'd5,  x: 12'd1234, y: 12'd567,  err: 1'b0};
      tbl[3] = '{idx: 5'd15, x: 12'd4095, y: 12'd4095, err: 1'b0};
      tbl[4] = '{idx: 5'd3,  x: 12'd1,    y: 12'd2,    err: 1'b0};
      tbl[5] = '{idx: 5'd20, x: 12'd7,    y: 12'd7,    err: 1'b1};

      rst_n = 1'b0; wr_valid = 1'b0; wr_index = '0; wr_x = '0; wr_y = '0;
      commit = 1'b0; fval = 1'b0;
      model_clear();
      #23 rst_n = 1'b1;
      tick();
      chk("rst_ready", TW'(wr_ready), TW'(1));
      chk("rst_lut_valid", TW'(lut_valid), TW'(0));
      chk("rst_pending", TW'(pending), TW'(0));
      chk("rst_done", TW'(swap_done), TW'(0));
      chk("rst_count", TW'(swap_count), TW'(0));
      chk("rst_q_x", q_x, '0);

      // Basic load and commit in blanking
      for (int i = 0; i < 2; i++) do_write(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].err);
      commit_fval0("t1");
      chk("t1_x0", TW'(q_x[0 +: CW]), TW'(100));
      chk("t1_y0", TW'(q_y[0 +: CW]), TW'(50));
      chk("t1_x3", TW'(q_x[3*CW +: CW]), TW'(200));
      chk("t1_y3", TW'(q_y[3*CW +: CW]), TW'(75));
      chk("t1_x_rest", TW'(q_x[TW-1:4*CW]), '0);
      tick();
      chk("t1_done_pulse", TW'(swap_done), TW'(0));

      // Commit held off by an active frame
      for (int i = 2; i < 5; i++) do_write(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].err);
      fval = 1'b1; commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int c = 0; c < 50; c++) begin
         chk("t2_hold_pending", TW'(pending), TW'(1));
         chk("t2_hold_ready", TW'(wr_ready), TW'(0));
         chk("t2_hold_q_x", q_x, m_ax);
         tick();
      end
      fval = 1'b0;
      tick();
      chk("t2_swap_done_early", TW'(swap_done), TW'(0));
      chk("t2_q_x_early", q_x, m_ax);
      tick();
      swap_checks("t2");
      chk("t2_x3", TW'(q_x[3*CW +: CW]), TW'(1));
      chk("t2_x15", TW'(q_x[15*CW +: CW]), TW'(4095));

      // Out-of-range index is flagged and leaves the table alone
      prev_x = q_x; prev_y = q_y;
      do_write(tbl[5].idx, tbl[5].x, tbl[5].y, tbl[5].err);
      tick();
      chk("t3_err_one_pulse", TW'(index_err), TW'(0));
      commit_fval0("t3");
      chk("t3_x_unchanged", q_x, prev_x);
      chk("t3_y_unchanged", q_y, prev_y);

      // Write in the commit cycle is included; writes while busy are dropped; held commit repeats
      wr_valid = 1'b1; wr_index = 5'd1; wr_x = 12'd300; wr_y = 12'd10; commit = 1'b1;
      tick();
      m_sx[1*CW +: CW] = 12'd300; m_sy[1*CW +: CW] = 12'd10;
      wr_index = 5'd2; wr_x = 12'd55; wr_y = 12'd66;
      chk("t4_e0_pending", TW'(pending), TW'(1));
      tick();
      tick();
      swap_checks("t4");
      chk("t4_x1", TW'(q_x[1*CW +: CW]), TW'(300));
      chk("t4_y1", TW'(q_y[1*CW +: CW]), TW'(10));
      chk("t4_x2_dropped", TW'(q_x[2*CW +: CW]), TW'(0));
      chk("t4_narrow_wrap", TW'(n_swap_count), TW'(0));
      wr_valid = 1'b0;
      tick();
      chk("t4_recommit_pending", TW'(pending), TW'(1));
      commit = 1'b0;
      tick();
      tick();
      swap_checks("t4r");

      // Asynchronous reset while pending
      do_write(5'd7, 12'd9, 12'd9, 1'b0);
      fval = 1'b1; commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      chk("t5_pending", TW'(pending), TW'(0));
      chk("t5_lut_valid", TW'(lut_valid), TW'(0));
      chk("t5_done", TW'(swap_done), TW'(0));
      chk("t5_count", TW'(swap_count), TW'(0));
      chk("t5_q_x", q_x, '0);
      chk("t5_q_y", q_y, '0);
      chk("t5_ready", TW'(wr_ready), TW'(1));
      #3 rst_n = 1'b1;
      fval = 1'b0;
      tick();
      commit_fval0("t5");
      chk("t5_zero_q_x", q_x, '0);

      // Counter wrap on the narrow copy
      do_write(5'd9, 12'd11, 12'd22, 1'b0);
      commit_fval0("t6a");
      commit_fval0("t6b");
      commit_fval0("t6c");
      chk("t6_wrap_count", TW'(n_swap_count), TW'(0));
      chk("t6_wrap_done", TW'(n_swap_done), TW'(1));
      chk("t6_wide_count", TW'(swap_count), TW'(4));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
